// File: rtl/trng_reader_if.sv
// trng_reader_if: bit-stream input, read handshake and status signals of the TRNG reader
interface trng_reader_if #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    logic                          bit_in;
    logic                          bit_valid;
    logic                          rd_req;
    logic                          clear_fail;
    logic [WORD_W-1:0]             rd_data;
    logic                          rd_valid;
    logic                          rd_err;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          health_fail;
    logic                          overflow;

    modport master (
        output bit_in, bit_valid, rd_req, clear_fail,
        input  rd_data, rd_valid, rd_err, level, health_fail, overflow
    );

    modport slave (
        input  bit_in, bit_valid, rd_req, clear_fail,
        output rd_data, rd_valid, rd_err, level, health_fail, overflow
    );
endinterface

// File: rtl/trng_reader.sv
// trng_reader: samples TRNG bits, runs a repetition-count health test, packs words into a FIFO for core reads
module trng_reader #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_CUTOFF = 32
) (
    input logic          clk,
    input logic          rstn,
    trng_reader_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WORD_W);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
    localparam logic [RW-1:0] CUT  = RW'(RCT_CUTOFF);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]     bit_cnt;
    logic [RW-1:0]     run, run_nxt;
    logic              last_bit;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              sample, trip, complete, empty, pop, push, drop;

    // run == 0 marks "no previous bit", so the first bit after reset/clear starts a run of 1
    always_comb begin
        sample   = bus.bit_valid && !bus.health_fail && !bus.clear_fail;
        run_nxt  = (run != '0 && bus.bit_in == last_bit) ? ((run == CUT) ? run : run + 1'b1) : RW'(1);
        trip     = sample && run_nxt == CUT;
        complete = sample && bit_cnt == LAST && !trip;
        empty    = bus.level == '0;
        pop      = bus.rd_req && !empty;
        push     = complete && (bus.level != FULL || pop);
        drop     = complete && !push;
    end

    // shift register, bit counter and repetition-count tracking
    always_ff @(posedge clk) begin
        if (!rstn || bus.clear_fail) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            run      <= '0;
            last_bit <= 1'b0;
        end else if (trip) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            run      <= run_nxt;
            last_bit <= bus.bit_in;
        end else if (sample) begin
            sreg     <= {sreg[WORD_W-2:0], bus.bit_in};
            bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            run      <= run_nxt;
            last_bit <= bus.bit_in;
        end
    end

    // sticky health and overflow flags; clear_fail wins over a same-cycle trip
    always_ff @(posedge clk) begin
        if (!rstn || bus.clear_fail) begin
            bus.health_fail <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            if (trip) bus.health_fail <= 1'b1;
            if (drop) bus.overflow    <= 1'b1;
        end
    end

    // FIFO storage: completed word enters at the write pointer
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sreg[WORD_W-2:0], bus.bit_in};
    end

    // FIFO pointers and level; a health trip flushes everything
    always_ff @(posedge clk) begin
        if (!rstn || trip) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bus.level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            bus.level <= bus.level + LW'(push) - LW'(pop);
        end
    end

    // read response one cycle after the request, taken from the pre-flush FIFO state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            bus.rd_err   <= bus.rd_req && empty;
            if (bus.rd_req) bus.rd_data <= empty ? '0 : mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_trng_reader.sv
// tb_trng_reader: vector table, directed corner sequences and randomized traffic against a queue-based model
module tb_trng_reader;
    localparam int W   = 32;
    localparam int D   = 4;
    localparam int CUT = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;
    int   cyc = 0;

    trng_reader_if #(.WORD_W(W), .FIFO_DEPTH(D)) t ();
    trng_reader #(.WORD_W(W), .FIFO_DEPTH(D), .RCT_CUTOFF(CUT)) dut (.clk(clk), .rstn(rstn), .bus(t));

    always #5 clk = ~clk;

    logic [W-1:0] m_q[$];
    logic [W-1:0] m_part;
    int           m_nbits, m_run;
    logic         m_last;
    logic         m_fail, m_ovf;
    logic [W-1:0] e_data;
    logic         e_valid, e_err;

    typedef struct {
        logic [W-1:0] word;
        logic         fail;
        int           lvl;
        logic [W-1:0] data;
        logic         err;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model(input logic b, input logic v, input logic r, input logic c, input logic rn);
        if (!rn) begin
            m_q.delete();
            m_part = '0; m_nbits = 0; m_run = 0; m_last = 1'b0;
            m_fail = 1'b0; m_ovf = 1'b0;
            e_data = '0; e_valid = 1'b0; e_err = 1'b0;
            return;
        end
        e_valid = r;
        e_err = 1'b0;
        if (r) begin
            if (m_q.size() > 0) e_data = m_q.pop_front();
            else begin e_data = '0; e_err = 1'b1; end
        end
        if (c) begin
            m_fail = 1'b0; m_ovf = 1'b0; m_run = 0; m_nbits = 0; m_part = '0; m_last = 1'b0;
        end else if (v && !m_fail) begin
            m_run = (m_run > 0 && b == m_last) ? ((m_run < CUT) ? m_run + 1 : CUT) : 1;
            m_last = b;
            m_part = {m_part[W-2:0], b};
            m_nbits++;
            if (m_run == CUT) begin
                m_fail = 1'b1; m_q.delete(); m_nbits = 0; m_part = '0;
            end else if (m_nbits == W) begin
                m_nbits = 0;
                if (m_q.size() < D) m_q.push_back(m_part);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic b, input logic v, input logic r, input logic c);
        t.bit_in = b; t.bit_valid = v; t.rd_req = r; t.clear_fail = c;
        @(posedge clk);
        model(b, v, r, c, rstn);
        #1;
        chk("rd_valid", W'(t.rd_valid), W'(e_valid));
        chk("rd_err", W'(t.rd_err), W'(e_err));
        chk("rd_data", t.rd_data, e_data);
        chk("level", W'(t.level), W'(m_q.size()));
        chk("health_fail", W'(t.health_fail), W'(m_fail));
        chk("overflow", W'(t.overflow), W'(m_ovf));
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(w[W-1-i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    initial begin
        vec_t vt[6];
        logic [W-1:0] ws[5];
        logic pb;
        int sticky;
        vt[0] = '{32'hDEADBEEF, 1'b0, 1, 32'hDEADBEEF, 1'b0};
        vt[1] = '{32'h00000001, 1'b0, 1, 32'h00000001, 1'b0};
        vt[2] = '{32'h80000000, 1'b0, 1, 32'h80000000, 1'b0};
        vt[3] = '{32'h00000000, 1'b1, 0, 32'h00000000, 1'b1};
        vt[4] = '{32'hFFFFFFFF, 1'b1, 0, 32'h00000000, 1'b1};
        vt[5] = '{32'hCAFEF00D, 1'b0, 1, 32'hCAFEF00D, 1'b0};
        t.bit_in = 1'b0; t.bit_valid = 1'b0; t.rd_req = 1'b0; t.clear_fail = 1'b0;

        do_reset();
        chk("reset level", W'(t.level), 0);
        chk("reset rd_data", t.rd_data, 0);

        for (int i = 0; i < 6; i++) begin
            clr();
            send(vt[i].word, W);
            chk("vec health_fail", W'(t.health_fail), W'(vt[i].fail));
            chk("vec level", W'(t.level), W'(vt[i].lvl));
            rd();
            chk("vec rd_valid", W'(t.rd_valid), 1);
            chk("vec rd_data", t.rd_data, vt[i].data);
            chk("vec rd_err", W'(t.rd_err), W'(vt[i].err));
        end

        do_reset();
        for (int i = 0; i < W; i++) step(i[0], 1'b1, 1'b0, 1'b0);
        chk("alt level", W'(t.level), 1);
        rd();
        chk("alt rd_data", t.rd_data, 32'h55555555);
        chk("alt rd_err", W'(t.rd_err), 0);
        chk("alt level after", W'(t.level), 0);

        ws[0] = 32'h11111111; ws[1] = 32'h22222222; ws[2] = 32'h33333333;
        ws[3] = 32'h44444444; ws[4] = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            send(ws[i], W);
            if (i == 3) chk("fill overflow pre", W'(t.overflow), 0);
        end
        chk("fill level", W'(t.level), 4);
        chk("fill overflow", W'(t.overflow), 1);
        for (int i = 0; i < 4; i++) begin
            rd();
            chk("drain rd_data", t.rd_data, ws[i]);
        end
        rd();
        chk("empty rd_err", W'(t.rd_err), 1);
        chk("empty rd_data", t.rd_data, 0);

        clr();
        send(32'hFFFFFFFF, 31);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 31);
        chk("rct 31 no fail", W'(t.health_fail), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 31);
        chk("rct 31 again", W'(t.health_fail), 0);
        chk("rct level pre", W'(t.level), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rct trip", W'(t.health_fail), 1);
        chk("rct flush", W'(t.level), 0);
        for (int i = 0; i < 10; i++) step(i[0], 1'b1, 1'b0, 1'b0);
        chk("rct halted", W'(t.level), 0);
        rd();
        chk("rct rd_err", W'(t.rd_err), 1);

        clr();
        chk("clear fail", W'(t.health_fail), 0);
        send(32'hA5A5A5A5, W);
        send(32'h5A5A5A5A, W);
        send(32'hFFFFFFFF, 31);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr vs trip", W'(t.health_fail), 0);
        send(32'hFFFFFFFF, 31);
        chk("run restarted", W'(t.health_fail), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rd();
        chk("preload 0", t.rd_data, 32'hA5A5A5A5);
        rd();
        chk("preload 1", t.rd_data, 32'h5A5A5A5A);
        rd();
        chk("post clr word", t.rd_data, 32'hFFFFFFFE);

        ws[0] = 32'h01234567; ws[1] = 32'h89ABCDEF; ws[2] = 32'h13579BDF;
        ws[3] = 32'h2468ACE0; ws[4] = 32'hF0F0F0F0;
        for (int i = 0; i < 4; i++) send(ws[i], W);
        send(ws[4], 31);
        step(ws[4][0], 1'b1, 1'b1, 1'b0);
        chk("pushpop overflow", W'(t.overflow), 0);
        chk("pushpop level", W'(t.level), 4);
        chk("pushpop rd_data", t.rd_data, ws[0]);
        for (int i = 1; i < 5; i++) begin
            rd();
            chk("pushpop drain", t.rd_data, ws[i]);
        end

        send(32'h12345678, 17);
        do_reset();
        send(32'hA5A5A5A5, W);
        chk("midreset level", W'(t.level), 1);
        rd();
        chk("midreset rd_data", t.rd_data, 32'hA5A5A5A5);
        chk("midreset level after", W'(t.level), 0);

        pb = 1'b0;
        sticky = 50;
        for (int i = 0; i < 4000; i++) begin
            logic b, v, r, c;
            if (i % 200 == 0) sticky = (($urandom % 2) == 0) ? 50 : 98;
            v = ($urandom % 4) != 0;
            b = (int'($urandom % 100) < sticky) ? pb : 1'($urandom);
            pb = b;
            r = ($urandom % 5) == 0;
            c = ($urandom % 300) == 0;
            rstn = ($urandom % 1500) != 0;
            step(b, v, r, c);
            rstn = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
